activation: RTL
===============

# activation

Parametrised, trainable neuron activation unit. Accepts a signed fixed-point argument, returns a saturated activation (sigmoid via ROM lookup, or ReLU), and in training mode accepts a back-propagated error and returns error × activation-derivative as feedback. Sits between a neuron's accumulator and the next layer, with all four interfaces on stb/rdy handshakes. It succeeds the fixed-width sigmoid unit, adding width parameters, a selectable ReLU mode and saturated feedback.

## Interface

Parameters:
- ARG_WIDTH, 16: argument, error and feedback width; signed, 8 fractional bits.
- RES_WIDTH, 8: result width; unsigned Q0.RES_WIDTH.
- DER_WIDTH, 9: derivative width; unsigned, 8 fractional bits, so 1.0 = 256.
- ADR_WIDTH, 12: ROM address width; depth 2**ADR_WIDTH.
- ACT_FILE, "": activation ROM init file.
- DER_FILE, "": derivative ROM init file.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  training enable, sampled at res handshake
- mode  in  1  0 = sigmoid, 1 = ReLU, sampled at arg handshake
- arg_stb / arg_rdy / arg_dat  in / out / in  1 / 1 / ARG_WIDTH  argument
- res_stb / res_rdy / res_dat  out / in / out  1 / 1 / RES_WIDTH  result
- err_stb / err_rdy / err_dat  in / out / in  1 / 1 / ARG_WIDTH  error
- fbk_stb / fbk_rdy / fbk_dat  out / in / out  1 / 1 / ARG_WIDTH  feedback

## Operation

- Handshake: a transfer occurs on a cycle where stb & rdy are both high. Producers hold stb and dat stable until the transfer.
- States and transitions:
  - ARG: on arg handshake, go to LUT.
  - LUT: go to RES.
  - RES: on res handshake, go to ERR if en, else ARG.
  - ERR: on err handshake, go to MUL.
  - MUL: go to FBK.
  - FBK: on fbk handshake, go to ARG.
- arg_rdy = (state == ARG); err_rdy = (state == ERR).
- Illegal state: go to ARG. In simulation, also report an error.
- Saturation: the registered argument is clamped to [-6.0, +6.0] (-1536 and +1536 raw). The ROM address is the clamped value[ADR_WIDTH-1:0] (two's complement index).
- Sigmoid mode: res = ACT ROM[adr]; grd = DER ROM[adr].
- ReLU mode:
  - res = 0 if arg ≤ 0; all-ones if arg ≥ 2**RES_WIDTH; otherwise arg[RES_WIDTH-1:0].
  - grd = 256 if arg > 0, else 0.
- grd is registered on the res handshake, only when en is high.
- Feedback: prd = err × grd, signed, full width ARG_WIDTH+DER_WIDTH+1, registered in MUL. fbk = prd >>> 8 (arithmetic), saturated to the signed ARG_WIDTH range.

## Timing

- Reset values: state ARG, arg_rdy 1, err_rdy 0, res_stb 0, fbk_stb 0, res_dat 0, fbk_dat 0, grd 0.
- Latency:
  - arg handshake to res_stb high: 2 cycles.
  - err handshake to fbk_stb high: 2 cycles.
- res_stb and res_dat stay stable while res_rdy is low. res_stb falls in the cycle after the handshake. fbk_stb and fbk_dat behave the same way.
- Throughput: one argument per 3 cycles when en = 0 and res_rdy is held high.
- en or mode changing mid-transaction has no effect on the current transaction.
- Reset asserted in any state: strobes drop immediately, the transaction is discarded, and state returns to ARG.
- err_stb asserted outside ERR is ignored, not lost; the producer holds it.

## Configuration

- ACTIVATION_RELU_EN defined: ReLU datapath compiled in; mode selects as above.
- Not defined: mode is ignored, sigmoid is always used, and no ReLU logic is synthesised.

## Structure

- Package activation_pkg holds:
  - state enum (ARG, LUT, RES, ERR, MUL, FBK)
  - FRAC = 8
  - ARG_MAX = +1536, ARG_MIN = -1536
  - GRD_ONE = 256
- Both ROMs use the existing rom sub-module (WIDTH, DEPTH, FILENAME; en, adr, dat). Read enable is high only in LUT.
- No further sub-modules.

## Test plan

- Sigmoid, en = 0, arg = 0x0000, res_rdy high: res_stb rises 2 cycles after the handshake, res_dat = ACT[0] (0x80 with the standard table), then arg_rdy is high again.
- Saturation: arg = 0x0800 reads address 0x600; arg = 0xF000 reads address 0xA00; arg = 0x0600 is not clamped.
- Training: en = 1, arg = 0x0000, DER[0] = 64, err = 0x0100 gives fbk_dat = 0x0040. err = 0xFF00 gives 0xFFC0. err = 0x7FFF with grd = 511 saturates to 0x7FFF.
- ReLU (macro defined, mode = 1, en = 1):
  - arg 0x0050: res 0x50; err 0x0123 gives fbk 0x0123.
  - arg 0xFF80: res 0x00, fbk 0x0000.
  - arg 0x0300: res 0xFF.
- Backpressure: res_rdy held low for 5 cycles keeps res_stb and res_dat stable and arg_rdy low; en toggled in that window, then sampled high at the handshake, enters ERR.
- Reset mid-FBK: fbk_stb drops asynchronously, arg_rdy = 1, and the next argument completes normally.

Source files
------------

// File: rtl/activation_pkg.sv
// Shared types and constants for the activation unit: FSM states, fixed-point
// constants and the built-in sigmoid/derivative table generator used by rom.
package activation_pkg;

    typedef enum logic [2:0] {
        ARG = 3'd0,
        LUT = 3'd1,
        RES = 3'd2,
        ERR = 3'd3,
        MUL = 3'd4,
        FBK = 3'd5
    } state_t;

    localparam int FRAC     = 8;
    localparam int ARG_MAX  = 1536;
    localparam int ARG_MIN  = -1536;
    localparam int GRD_ONE  = 256;

    localparam int TBL_ACT  = 0;
    localparam int TBL_DER  = 1;
    localparam int GRD_KNEE = 512;

    // Hard-sigmoid table: act = 0.5 + x/4 clamped to [0, 1); derivative 0.25 inside |x| < 2.
    function automatic int table_entry(input int kind, input int x, input int width);
        int v;
        int top;
        top = (32'sd1 <<< width) - 32'sd1;
        if (kind == TBL_DER) begin
            if (x > -GRD_KNEE && x < GRD_KNEE) v = GRD_ONE / 32'sd4;
            else v = 32'sd0;
        end else begin
            v = (32'sd1 <<< (width - 32'sd1)) + ((x <<< width) >>> 10);
            if (v < 32'sd0) v = 32'sd0;
            else if (v > top) v = top;
            else v = v;
        end
        return v;
    endfunction

endpackage

// File: rtl/rom.sv
// Synchronous-read ROM model; contents come from the package table generator
// when FILENAME is empty (external images are not modelled and read as zero).
module rom
    import activation_pkg::*;
#(
    parameter int    WIDTH    = 8,
    parameter int    DEPTH    = 4096,
    parameter string FILENAME = "",
    parameter int    TABLE    = TBL_ACT
)(
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] adr,
    output logic [WIDTH-1:0]         dat
);

    localparam bit BUILTIN = (FILENAME == "");

    // Registered read; the output holds its last value while en is low.
    always_ff @(posedge clk) begin
        if (en) begin
            if (BUILTIN) dat <= WIDTH'(table_entry(TABLE, int'($signed(adr)), WIDTH));
            else dat <= '0;
        end
    end

endmodule

// File: rtl/activation.sv
// Trainable activation unit: sigmoid via ROM or ReLU, with error x derivative feedback.
// Define ACTIVATION_RELU_EN to compile in the ReLU datapath selected by mode.
module activation
    import activation_pkg::*;
#(
    parameter int    ARG_WIDTH = 16,
    parameter int    RES_WIDTH = 8,
    parameter int    DER_WIDTH = 9,
    parameter int    ADR_WIDTH = 12,
    parameter string ACT_FILE  = "",
    parameter string DER_FILE  = ""
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 arg_stb,
    output logic                 arg_rdy,
    input  logic [ARG_WIDTH-1:0] arg_dat,
    output logic                 res_stb,
    input  logic                 res_rdy,
    output logic [RES_WIDTH-1:0] res_dat,
    input  logic                 err_stb,
    output logic                 err_rdy,
    input  logic [ARG_WIDTH-1:0] err_dat,
    output logic                 fbk_stb,
    input  logic                 fbk_rdy,
    output logic [ARG_WIDTH-1:0] fbk_dat
);

    localparam int PRD_WIDTH = ARG_WIDTH + DER_WIDTH + 1;

    localparam logic signed [ARG_WIDTH-1:0] ARG_HI  = ARG_WIDTH'(ARG_MAX);
    localparam logic signed [ARG_WIDTH-1:0] ARG_LO  = ARG_WIDTH'(ARG_MIN);
    localparam logic signed [PRD_WIDTH-1:0] FBK_MAX = PRD_WIDTH'((64'sd1 <<< (ARG_WIDTH - 1)) - 64'sd1);
    localparam logic signed [PRD_WIDTH-1:0] FBK_MIN = PRD_WIDTH'(-(64'sd1 <<< (ARG_WIDTH - 1)));

    state_t                        state;
    logic signed [ARG_WIDTH-1:0]   arg_r;
    logic signed [ARG_WIDTH-1:0]   sat_arg;
    logic [ADR_WIDTH-1:0]          adr;
    logic                          rom_en;
    logic [RES_WIDTH-1:0]          act_dat;
    logic [DER_WIDTH-1:0]          der_dat;
    logic [RES_WIDTH-1:0]          res_sel;
    logic [DER_WIDTH-1:0]          grd_sel;
    logic [DER_WIDTH-1:0]          grd_r;
    logic signed [PRD_WIDTH-1:0]   prd_r;
    logic [ARG_WIDTH-1:0]          fbk_r;
    logic                          res_stb_r;
    logic                          fbk_stb_r;
    logic                          arg_rdy_r;
    logic                          err_rdy_r;
    logic                          unused_sat;

    // Scale the product back to 8 fractional bits and clamp to the signed feedback range.
    function automatic logic [ARG_WIDTH-1:0] sat_fbk(input logic signed [PRD_WIDTH-1:0] p);
        logic signed [PRD_WIDTH-1:0] s;
        s = p >>> FRAC;
        if (s > FBK_MAX) return {1'b0, {(ARG_WIDTH-1){1'b1}}};
        else if (s < FBK_MIN) return {1'b1, {(ARG_WIDTH-1){1'b0}}};
        else return s[ARG_WIDTH-1:0];
    endfunction

    // Clamp the argument to +/-6.0 before it addresses the tables.
    always_comb begin
        sat_arg = arg_r;
        if (arg_r > ARG_HI) sat_arg = ARG_HI;
        else if (arg_r < ARG_LO) sat_arg = ARG_LO;
        else sat_arg = arg_r;
    end

    assign adr        = sat_arg[ADR_WIDTH-1:0];
    assign unused_sat = ^sat_arg[ARG_WIDTH-1:ADR_WIDTH];
    assign rom_en     = (state == LUT);

    rom #(
        .WIDTH    (RES_WIDTH),
        .DEPTH    (2 ** ADR_WIDTH),
        .FILENAME (ACT_FILE),
        .TABLE    (TBL_ACT)
    ) act_rom (
        .clk (clk),
        .en  (rom_en),
        .adr (adr),
        .dat (act_dat)
    );

    rom #(
        .WIDTH    (DER_WIDTH),
        .DEPTH    (2 ** ADR_WIDTH),
        .FILENAME (DER_FILE),
        .TABLE    (TBL_DER)
    ) der_rom (
        .clk (clk),
        .en  (rom_en),
        .adr (adr),
        .dat (der_dat)
    );

`ifdef ACTIVATION_RELU_EN
    localparam logic signed [ARG_WIDTH-1:0] RELU_TOP = ARG_WIDTH'(32'sd1 <<< RES_WIDTH);

    logic                 mode_r;
    logic [RES_WIDTH-1:0] relu_res;
    logic                 relu_pos;
    logic                 arg_pos;

    assign arg_pos = !arg_r[ARG_WIDTH-1] && (arg_r != '0);

    // ReLU result is formed during LUT so it lines up with the ROM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r   <= 1'b0;
            relu_res <= '0;
            relu_pos <= 1'b0;
        end else begin
            if (state == ARG && arg_stb) mode_r <= mode;
            if (state == LUT) begin
                relu_pos <= arg_pos;
                if (!arg_pos) relu_res <= '0;
                else if (arg_r >= RELU_TOP) relu_res <= '1;
                else relu_res <= arg_r[RES_WIDTH-1:0];
            end
        end
    end

    // Select the result and gradient source captured with this argument.
    always_comb begin
        res_sel = act_dat;
        grd_sel = der_dat;
        if (mode_r) begin
            res_sel = relu_res;
            grd_sel = relu_pos ? DER_WIDTH'(GRD_ONE) : '0;
        end else begin
            res_sel = act_dat;
            grd_sel = der_dat;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    // Sigmoid-only build: tables feed result and gradient directly.
    always_comb begin
        res_sel = act_dat;
        grd_sel = der_dat;
    end
`endif

    // Transaction FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARG;
            arg_rdy_r <= 1'b1;
            err_rdy_r <= 1'b0;
            res_stb_r <= 1'b0;
            fbk_stb_r <= 1'b0;
            arg_r     <= '0;
            grd_r     <= '0;
            prd_r     <= '0;
            fbk_r     <= '0;
        end else begin
            case (state)
                ARG: begin
                    if (arg_stb) begin
                        arg_r     <= arg_dat;
                        arg_rdy_r <= 1'b0;
                        state     <= LUT;
                    end
                end
                LUT: begin
                    res_stb_r <= 1'b1;
                    state     <= RES;
                end
                RES: begin
                    if (res_rdy) begin
                        res_stb_r <= 1'b0;
                        if (en) begin
                            grd_r     <= grd_sel;
                            err_rdy_r <= 1'b1;
                            state     <= ERR;
                        end else begin
                            arg_rdy_r <= 1'b1;
                            state     <= ARG;
                        end
                    end
                end
                ERR: begin
                    if (err_stb) begin
                        prd_r     <= PRD_WIDTH'($signed(err_dat)) * PRD_WIDTH'($signed({1'b0, grd_r}));
                        err_rdy_r <= 1'b0;
                        state     <= MUL;
                    end
                end
                MUL: begin
                    fbk_r     <= sat_fbk(prd_r);
                    fbk_stb_r <= 1'b1;
                    state     <= FBK;
                end
                FBK: begin
                    if (fbk_rdy) begin
                        fbk_stb_r <= 1'b0;
                        arg_rdy_r <= 1'b1;
                        state     <= ARG;
                    end
                end
                default: begin
                    state     <= ARG;
                    arg_rdy_r <= 1'b1;
                    err_rdy_r <= 1'b0;
                    res_stb_r <= 1'b0;
                    fbk_stb_r <= 1'b0;
`ifndef SYNTHESIS
                    $error("activation: illegal state %0d", state);
`endif
                end
            endcase
        end
    end

    assign arg_rdy = arg_rdy_r;
    assign err_rdy = err_rdy_r;
    assign res_stb = res_stb_r;
    assign fbk_stb = fbk_stb_r;
    assign fbk_dat = fbk_r;
    assign res_dat = res_stb_r ? res_sel : '0;

endmodule
